// File: rtl/key_debounce_if.sv
// key_debounce_if: raw active-low button in, debounced level and strobes out
interface key_debounce_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;
  modport master (output key_in, input key_level, key_press, key_release, key_long);
  modport slave (input key_in, output key_level, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: sync + stability-count debouncer for an active-low key; KEY_LONG_PRESS_EN adds a long-press strobe
module key_debounce #(
  parameter int CNT_MAX  = 1_000_000,
  parameter int CNT_W    = 20,
  parameter int LONG_MAX = 100_000_000,
  parameter int LONG_W   = 27
) (
  input logic sclk,
  input logic rst_n,
  key_debounce_if.slave ifc
);
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    PRESS_CHK = 4'b0010,
    DOWN      = 4'b0100,
    REL_CHK   = 4'b1000
  } state_t;
  state_t state, state_n;
  logic s1, s2;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic level, level_n, press, press_n, rel, rel_n;
  logic pressed, cnt_done;
  assign pressed  = ~s2;
  assign cnt_done = cnt == CNT_W'(CNT_MAX - 1);
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= ifc.key_in;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      press <= press_n;
      rel   <= rel_n;
    end
  end
  // any opposite sample during a check phase restarts from the stable side
  always_comb begin
    state_n = IDLE;
    cnt_n   = '0;
    level_n = 1'b0;
    press_n = 1'b0;
    rel_n   = 1'b0;
    case (state)
      IDLE: state_n = pressed ? PRESS_CHK : IDLE;
      PRESS_CHK: begin
        state_n = !pressed ? IDLE : cnt_done ? DOWN : PRESS_CHK;
        cnt_n   = (pressed && !cnt_done) ? cnt + 1'b1 : '0;
        level_n = pressed && cnt_done;
        press_n = pressed && cnt_done;
      end
      DOWN: begin
        state_n = pressed ? DOWN : REL_CHK;
        level_n = 1'b1;
      end
      REL_CHK: begin
        state_n = pressed ? DOWN : cnt_done ? IDLE : REL_CHK;
        cnt_n   = (!pressed && !cnt_done) ? cnt + 1'b1 : '0;
        level_n = pressed || !cnt_done;
        rel_n   = !pressed && cnt_done;
      end
      default: ;
    endcase
  end
  assign ifc.key_level   = level;
  assign ifc.key_press   = press;
  assign ifc.key_release = rel;
`ifdef KEY_LONG_PRESS_EN
  logic [LONG_W-1:0] lcnt, lcnt_n;
  logic lfired, lfired_n, lng, lng_n, lsat;
  assign lsat = lcnt == LONG_W'(LONG_MAX - 1);
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt   <= '0;
      lfired <= 1'b0;
      lng    <= 1'b0;
    end else begin
      lcnt   <= lcnt_n;
      lfired <= lfired_n;
      lng    <= lng_n;
    end
  end
  // lfired keeps the strobe to one per press while lcnt sits saturated
  always_comb begin
    lng_n    = state == DOWN && lsat && !lfired;
    lcnt_n   = state == DOWN ? (lsat ? lcnt : lcnt + 1'b1) : state == REL_CHK ? lcnt : '0;
    lfired_n = state == DOWN ? (lfired || lng_n) : state == REL_CHK ? lfired : 1'b0;
  end
  assign ifc.key_long = lng;
`else
  assign ifc.key_long = (LONG_MAX < 1) && (LONG_W < 1);
`endif
endmodule
